// File: rtl/vol_bar_sequencer.sv
// vol_bar_sequencer: windowed mic peak -> 0..16 bar level with frame-synchronous attack/decay and peak-hold marker
// Ports:
//   my_clock      system clock, rising edge
//   reset_n       asynchronous active-low reset
//   sample_valid  strobe qualifying mic_in
//   mic_in        unsigned 12-bit mic sample, midscale 2048
//   frame_start   strobe at pixel_index 0; display state only moves here
//   freeze        high holds level, peak marker and all frame counters
//   level         displayed bar count 0..16
//   peak_level    peak-hold marker 0..16, never below level
//   level_valid   one-cycle pulse after each frame update
//   led           thermometer of level, one cycle behind level
module vol_bar_sequencer #(
    parameter int WINDOW       = 4000,
    parameter int HOLD_FRAMES  = 30,
    parameter int DECAY_FRAMES = 3
) (
    input  logic        my_clock,
    input  logic        reset_n,
    input  logic        sample_valid,
    input  logic [11:0] mic_in,
    input  logic        frame_start,
    input  logic        freeze,
    output logic [4:0]  level,
    output logic [4:0]  peak_level,
    output logic        level_valid,
    output logic [15:0] led
);
    typedef enum logic [1:0] {TRACK, HOLD, DECAY} peak_state_t;
    localparam logic [11:0] WIN_LAST  = 12'(WINDOW - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0]  DEC_LAST  = 8'(DECAY_FRAMES - 1);
    peak_state_t state, state_nx;
    logic [10:0] max_amp, amp, cur_max;
    logic [11:0] sample_cnt, rounded;
    logic [4:0]  target, quant, level_nx, peak_nx, peak_dec;
    logic [7:0]  hold_cnt, decay_cnt, peak_decay_cnt, hold_nx, decay_nx, pdc_nx;
    logic        upd, win_end;
    logic [16:0] therm;

    assign amp      = mic_in[11] ? mic_in[10:0] : '0;
    assign cur_max  = amp > max_amp ? amp : max_amp;
    assign win_end  = sample_valid && sample_cnt == WIN_LAST;
    // round-up quantisation in 128-count steps; 2047+127 tops out at exactly 16
    assign rounded  = {1'b0, cur_max} + 12'd127;
    assign quant    = rounded[11:7] > 5'd16 ? 5'd16 : rounded[11:7];
    assign upd      = frame_start && !freeze;
    assign therm    = (17'd1 << level) - 17'd1;
    assign peak_dec = peak_level - 5'd1;

    always_comb begin
        level_nx = level;
        decay_nx = decay_cnt;
        if (target > level) begin
            level_nx = target;
            decay_nx = '0;
        end else if (target < level) begin
            level_nx = decay_cnt == DEC_LAST ? level - 5'd1 : level;
            decay_nx = decay_cnt == DEC_LAST ? 8'd0 : decay_cnt + 8'd1;
        end else begin
            decay_nx = '0;
        end
    end

    // peak marker follows the level computed for this same frame
    always_comb begin
        state_nx = state;
        peak_nx  = peak_level;
        hold_nx  = hold_cnt;
        pdc_nx   = peak_decay_cnt;
        case (state)
            TRACK: begin
                if (level_nx > peak_level)
                    peak_nx = level_nx;
                if (level_nx != 5'd0 && level_nx >= peak_level) begin
                    state_nx = HOLD;
                    hold_nx  = '0;
                end
            end
            HOLD: begin
                if (level_nx > peak_level) begin
                    peak_nx = level_nx;
                    hold_nx = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nx = DECAY;
                    pdc_nx   = '0;
                end else begin
                    hold_nx = hold_cnt + 8'd1;
                end
            end
            DECAY: begin
                if (level_nx >= peak_level) begin
                    peak_nx  = level_nx;
                    state_nx = HOLD;
                    hold_nx  = '0;
                end else if (peak_decay_cnt == DEC_LAST) begin
                    pdc_nx   = '0;
                    peak_nx  = peak_dec <= level_nx ? level_nx : peak_dec;
                    state_nx = peak_dec <= level_nx ? TRACK : DECAY;
                end else begin
                    pdc_nx = peak_decay_cnt + 8'd1;
                end
            end
            default: state_nx = TRACK;
        endcase
    end

    always_ff @(posedge my_clock or negedge reset_n) begin
        if (!reset_n)
            state <= TRACK;
        else if (upd)
            state <= state_nx;
    end

    always_ff @(posedge my_clock or negedge reset_n) begin
        if (!reset_n) begin
            max_amp        <= '0;
            sample_cnt     <= '0;
            target         <= '0;
            level          <= '0;
            peak_level     <= '0;
            hold_cnt       <= '0;
            decay_cnt      <= '0;
            peak_decay_cnt <= '0;
            level_valid    <= 1'b0;
            led            <= '0;
        end else begin
            level_valid <= upd;
            led         <= therm[15:0];
            if (sample_valid) begin
                max_amp    <= win_end ? 11'd0 : cur_max;
                sample_cnt <= win_end ? 12'd0 : sample_cnt + 12'd1;
            end
            if (win_end)
                target <= quant;
            if (upd) begin
                level          <= level_nx;
                decay_cnt      <= decay_nx;
                peak_level     <= peak_nx;
                hold_cnt       <= hold_nx;
                peak_decay_cnt <= pdc_nx;
            end
        end
    end
endmodule

// File: tb/tb_vol_bar_sequencer.sv
// tb_vol_bar_sequencer: directed scoreboard bench for vol_bar_sequencer with WINDOW=4
module tb_vol_bar_sequencer;
    localparam int W = 4;
    localparam int H = 30;
    localparam int D = 3;

    logic        my_clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] mic_in = '0;
    logic        frame_start = 1'b0;
    logic        freeze = 1'b0;
    logic [4:0]  level, peak_level;
    logic        level_valid;
    logic [15:0] led;

    typedef struct {int lv; int pk;} exp_t;
    exp_t sb[$];
    int n_assert = 0;
    int n_fail = 0;
    int m_level, m_peak, m_state, m_hold, m_dc, m_pdc, m_target, m_max, m_cnt;

    always #5 my_clock = ~my_clock;

    vol_bar_sequencer #(.WINDOW(W), .HOLD_FRAMES(H), .DECAY_FRAMES(D)) dut (
        .my_clock(my_clock), .reset_n(reset_n), .sample_valid(sample_valid),
        .mic_in(mic_in), .frame_start(frame_start), .freeze(freeze),
        .level(level), .peak_level(peak_level), .level_valid(level_valid), .led(led)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int therm(input int l);
        int r = 0;
        for (int i = 0; i < 16; i++)
            if (i < l) r |= (1 << i);
        return r;
    endfunction

    task automatic m_reset();
        m_level = 0; m_peak = 0; m_state = 0; m_hold = 0; m_dc = 0;
        m_pdc = 0; m_target = 0; m_max = 0; m_cnt = 0;
        sb.delete();
    endtask

    task automatic m_sample(input int v);
        int a = v >= 2048 ? v - 2048 : 0;
        if (a > m_max) m_max = a;
        if (m_cnt == W - 1) begin
            m_target = (m_max + 127) / 128;
            if (m_target > 16) m_target = 16;
            m_max = 0;
            m_cnt = 0;
        end else m_cnt++;
    endtask

    task automatic m_frame();
        exp_t e;
        if (m_target > m_level) begin
            m_level = m_target; m_dc = 0;
        end else if (m_target < m_level) begin
            if (m_dc == D - 1) begin m_level--; m_dc = 0; end
            else m_dc++;
        end else m_dc = 0;
        case (m_state)
            0: begin
                if (m_level > 0 && m_level >= m_peak) begin m_state = 1; m_hold = 0; end
                if (m_level > m_peak) m_peak = m_level;
            end
            1: begin
                if (m_level > m_peak) begin m_peak = m_level; m_hold = 0; end
                else if (m_hold == H - 1) begin m_state = 2; m_pdc = 0; end
                else m_hold++;
            end
            default: begin
                if (m_level >= m_peak) begin m_peak = m_level; m_state = 1; m_hold = 0; end
                else if (m_pdc == D - 1) begin
                    m_pdc = 0;
                    if (m_peak - 1 <= m_level) begin m_peak = m_level; m_state = 0; end
                    else m_peak--;
                end else m_pdc++;
            end
        endcase
        e.lv = m_level;
        e.pk = m_peak;
        sb.push_back(e);
    endtask

    task automatic collect();
        exp_t e;
        int t = 0;
        while (!level_valid && t < 3) begin @(negedge my_clock); t++; end
        if (!level_valid) begin
            chk("valid_timeout", {31'd0, level_valid}, 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk("level", level, e.lv);
            chk("peak", peak_level, e.pk);
            @(negedge my_clock);
            chk("led", led, therm(e.lv));
            chk("valid_pulse", {31'd0, level_valid}, 0);
        end
    endtask

    task automatic cycle(input bit sv, input int v, input bit fs);
        sample_valid = sv;
        mic_in = 12'(v);
        frame_start = fs;
        @(negedge my_clock);
        sample_valid = 1'b0;
        frame_start = 1'b0;
        if (fs && !freeze) m_frame();
        if (sv) m_sample(v);
        if (fs && !freeze) collect();
        else chk("no_valid", {31'd0, level_valid}, 0);
    endtask

    initial begin
        m_reset();
        repeat (3) @(negedge my_clock);
        chk("rst_level", level, 0);
        chk("rst_peak", peak_level, 0);
        chk("rst_led", led, 0);
        chk("rst_valid", {31'd0, level_valid}, 0);
        reset_n = 1'b1;
        // 1: quiet window
        repeat (4) cycle(1, 2048, 0);
        cycle(0, 0, 1);
        chk("t1_level", level, 0);
        // 2: full-scale window
        repeat (3) cycle(1, 2048, 0);
        cycle(1, 4095, 0);
        cycle(0, 0, 1);
        chk("t2_level", level, 16);
        chk("t2_peak", peak_level, 16);
        chk("t2_led", led, 16'hFFFF);
        // 3: silence decay and peak hold
        repeat (4) cycle(1, 1000, 0);
        for (int k = 1; k <= 80; k++) begin
            cycle(0, 0, 1);
            if (k == 2)  chk("t3_lvl_f2", level, 16);
            if (k == 3)  chk("t3_lvl_f3", level, 15);
            if (k == 32) chk("t3_pk_f32", peak_level, 16);
            if (k == 33) chk("t3_pk_f33", peak_level, 15);
            if (k == 47) chk("t3_lvl_f47", level, 1);
            if (k == 48) chk("t3_lvl_f48", level, 0);
            if (k == 77) chk("t3_pk_f77", peak_level, 1);
            if (k == 78) chk("t3_pk_f78", peak_level, 0);
        end
        // 4: window end coincides with frame_start
        repeat (3) cycle(1, 2048, 0);
        cycle(1, 2048 + 129, 1);
        chk("t4_same_frame", level, 0);
        cycle(0, 0, 1);
        chk("t4_next_frame", level, 2);
        chk("t4_peak", peak_level, 2);
        // 5: freeze
        freeze = 1'b1;
        repeat (4) cycle(1, 4095, 0);
        repeat (3) begin
            cycle(0, 0, 1);
            chk("t5_frozen_lvl", level, 2);
            chk("t5_frozen_pk", peak_level, 2);
        end
        freeze = 1'b0;
        cycle(0, 0, 1);
        chk("t5_release", level, 16);
        // 6: asynchronous reset mid-window
        repeat (2) cycle(1, 4095, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_level", level, 0);
        chk("t6_peak", peak_level, 0);
        chk("t6_led", led, 0);
        chk("t6_valid", {31'd0, level_valid}, 0);
        m_reset();
        @(negedge my_clock);
        reset_n = 1'b1;
        repeat (3) cycle(1, 4095, 0);
        cycle(0, 0, 1);
        chk("t6_partial", level, 0);
        cycle(1, 4095, 0);
        cycle(0, 0, 1);
        chk("t6_full", level, 16);
        chk("t6_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
